// File: rtl/branch_pkg.sv
// Shared opcode encoding, resolution FSM states and BTB entry layout for the
// decode-stage branch unit.
package branch_pkg;

  typedef enum logic [3:0] {
    PC_INIT = 4'd0,
    ADDI    = 4'd1,
    ADDS    = 4'd2,
    BLT     = 4'd3,
    B       = 4'd4,
    CBZ     = 4'd5,
    LDUR    = 4'd6,
    LSL     = 4'd7,
    LSR     = 4'd8,
    MUL     = 4'd9,
    STUR    = 4'd10,
    SUBS    = 4'd11,
    INV     = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {RUN, REDIR, SQUASH} bru_state_t;

  // Entries are sized for the widest PC; narrower builds zero-extend into them.
  localparam int BTB_TAG_W = 64;
  localparam int BTB_TGT_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer plus saturating-counter history table.
// Combinational lookup from fetch PC; one write per cycle from decode resolution.
module btb_table
  import branch_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int CTR_W  = 2,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              lookup_taken,
  output logic [ADDR_W-1:0] lookup_target,
  input  logic              upd_en,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_W'(1);

  btb_entry_t       entries [DEPTH];
  logic [CTR_W-1:0] ctrs    [DEPTH];

  logic [IDX_W-1:0]     rd_idx, wr_idx;
  logic [BTB_TAG_W-1:0] rd_tag, wr_tag;
  btb_entry_t           rd_entry, wr_cur, wr_entry;
  logic [CTR_W-1:0]     cur_ctr, wr_ctr;
  logic                 wr_hit, wr_en;
  logic                 unused_bits;

  assign rd_idx = lookup_pc[IDX_W+1:2];
  assign rd_tag = BTB_TAG_W'(lookup_pc[ADDR_W-1:IDX_W+2]);
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = BTB_TAG_W'(upd_pc[ADDR_W-1:IDX_W+2]);
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_entry      = entries[rd_idx];
  assign lookup_taken  = rd_entry.valid && (rd_entry.tag == rd_tag) && ctrs[rd_idx][CTR_W-1];
  assign lookup_target = rd_entry.target[ADDR_W-1:0];

  assign wr_cur  = entries[wr_idx];
  assign cur_ctr = ctrs[wr_idx];
  assign wr_hit  = wr_cur.valid && (wr_cur.tag == wr_tag);
  // Non-branches only touch the table to evict a stale alias they hit.
  assign wr_en   = upd_en && (upd_is_branch || wr_hit);

  always_comb begin
    wr_entry = wr_cur;
    wr_ctr   = cur_ctr;
    if (!upd_is_branch) begin
      wr_entry.valid = 1'b0;
    end else if (wr_hit) begin
      if (upd_taken) begin
        wr_entry.target = BTB_TGT_W'(upd_target);
        if (cur_ctr != CTR_MAX) wr_ctr = cur_ctr + 1'b1;
      end else if (cur_ctr != '0) begin
        wr_ctr = cur_ctr - 1'b1;
      end
    end else begin
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = wr_tag;
      wr_entry.target = BTB_TGT_W'(upd_target);
      wr_ctr          = upd_taken ? CTR_WEAK_T : CTR_WEAK_N;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
        ctrs[i]    <= CTR_WEAK_N;
      end
    end else if (wr_en) begin
      entries[wr_idx] <= wr_entry;
      ctrs[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Decode-stage branch resolution with redirect/flush sequencing and an optional
// fetch-side BTB predictor, built only when BRU_PREDICT_EN is defined.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 64,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [3:0]        id_opcode,
  input  logic [ADDR_W-1:0] id_imm19,
  input  logic [ADDR_W-1:0] id_imm26,
  input  logic [ADDR_W-1:0] id_db,
  input  logic              id_n,
  input  logic              id_v,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pred_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush
);

  bru_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] redirect_pc_reg;
  logic              accept, is_branch, actual_taken, mispredict;
  logic [ADDR_W-1:0] br_target, correct_pc;

  always_comb begin
    is_branch    = 1'b0;
    actual_taken = 1'b0;
    br_target    = id_pc + (id_imm19 << 2);
    case (id_opcode)
      B: begin
        is_branch    = 1'b1;
        actual_taken = 1'b1;
        br_target    = id_pc + (id_imm26 << 2);
      end
      BLT: begin
        is_branch    = 1'b1;
        actual_taken = id_n ^ id_v;
      end
      CBZ: begin
        is_branch    = 1'b1;
        actual_taken = (id_db == '0);
      end
      default: ;
    endcase
  end

  assign accept     = id_valid && !id_stall && (state_reg == RUN);
  assign correct_pc = actual_taken ? br_target : id_pc + ADDR_W'(4);
  // A non-branch is never taken, so a predicted-taken alias falls out here too.
  assign mispredict = (id_pred_taken != actual_taken) ||
                      (id_pred_taken && actual_taken && (id_pred_target != br_target));

  always_comb begin
    state_next     = state_reg;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_reg)
      RUN:     if (accept && mispredict) state_next = REDIR;
      REDIR: begin
        state_next     = SQUASH;
        redirect_valid = 1'b1;
        flush          = 1'b1;
      end
      SQUASH: begin
        state_next = RUN;
        flush      = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && mispredict) redirect_pc_reg <= correct_pc;
    end
  end

  assign redirect_pc = redirect_pc_reg;

`ifdef BRU_PREDICT_EN
  btb_table #(
    .DEPTH (DEPTH),
    .CTR_W (CTR_W),
    .ADDR_W(ADDR_W)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc    (if_pc),
    .lookup_taken (if_pred_taken),
    .lookup_target(if_pred_target),
    .upd_en       (accept),
    .upd_is_branch(is_branch),
    .upd_taken    (actual_taken),
    .upd_pc       (id_pc),
    .upd_target   (br_target)
  );
`else
  logic unused_pred;
  assign unused_pred    = ^{if_pc, is_branch};
  assign if_pred_taken  = 1'b0;
  assign if_pred_target = '0;
`endif

endmodule
